des_key_sched: RTL
==================

# des_key_sched

Sequencer for the DES key schedule. It sits between the key register and the round datapath. A `start` loads a 64-bit key through the existing PC1 permutation into the C/D halves. The block then rotates C/D per round and streams the 16 PC2 subkeys to the round engine over a valid/ready handshake, in encrypt order (K1..K16) or decrypt order (K16..K1).

## Interface
Parameters:
- none. All widths and the shift schedule are fixed by DES and held as package constants.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `decrypt`  in  1  sampled with `start`: 0 = K1..K16, 1 = K16..K1.
- `key`  in  65  DES bit n on `key[n]`, n = 1..64; `key[0]` ignored.
- `busy`  out  1  high from the cycle after `start` is accepted until the last subkey handshake.
- `sk_valid`  out  1  `subkey` is presented.
- `sk_ready`  in  1  round engine accepts `subkey`.
- `subkey`  out  49  DES subkey bit n on `subkey[n]`, n = 1..48; `subkey[0]` is 0.
- `round`  out  4  index of the presented subkey, 0..15, in stream order.
- `last`  out  1  high with `sk_valid` on the 16th subkey.
- `done`  out  1  one-cycle pulse after the last handshake.
- `key_err`  out  1  parity error flag; present only with `DES_KS_PARITY_EN`.

## Operation
- FSM states: IDLE, ROUND.
- **IDLE.** On `start` = 1:
  - C/D ← PC1(`key`), rotated by the first shift: left 1 for encrypt, 0 for decrypt.
  - Latch `decrypt`, clear the round counter, go to ROUND.
- **ROUND.**
  - `sk_valid` = 1; `subkey` = PC2(C,D) combinational from the C/D registers.
  - On `sk_valid & sk_ready` with round < 15: increment the round counter, then rotate C and D independently by the next schedule entry.
    - Encrypt: left rotate by SHIFT[round+1].
    - Decrypt: right rotate by SHIFT[16−round].
    - SHIFT is 1-indexed: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - On handshake with round = 15: go to IDLE and pulse `done`.
- **Stability.** While `sk_valid & !sk_ready`, the outputs `subkey`, `round` and `last` are held stable.
- **Ignored inputs.** `start` is ignored in ROUND. `key` and `decrypt` are don't-care except in the `start` cycle.
- **Reset.** Reset outputs are all 0: `busy`, `sk_valid`, `round`, `last`, `done`, `key_err`, `subkey`. C/D are cleared. State goes to IDLE. Reset asserted mid-stream aborts without a `done`.
- **Wrap-around.** After 16 rotations, C/D equal their loaded value. No wrap check is required; the counter stops at 15.

## Timing
- `start` sampled at edge T → `sk_valid`/`busy` high in cycle T+1 with K1 (or K16 in decrypt mode).
- With `sk_ready` held high, one subkey per cycle: cycles T+1..T+16. `done` is high in T+17.
- Back-to-back: `start` is accepted in the cycle `done` is high. The next key stream begins in the following cycle.
- Latency from handshake to next subkey: 1 cycle. There are no bubbles.

## Configuration
- **`DES_KS_PARITY_EN` defined:**
  - At `start`, every key byte (bits 8k−7..8k) is checked for odd parity.
  - On any even byte, the key is rejected: state stays IDLE, `busy` stays low, and `key_err` = 1 for one cycle (T+1).
- **`DES_KS_PARITY_EN` undefined:**
  - Parity bits are ignored.
  - The `key_err` port is omitted.

## Structure
- **Package `des_pkg`:**
  - SHIFT_SCHED (16 × 2-bit) constant.
  - State enum (IDLE, ROUND).
  - Width constants: KEY_W = 64, HALF_W = 28, SK_W = 48.
- **Instantiations:**
  - The existing PC1 module for the load path.
  - One new combinational sub-module, `des_pc2` (56→48 selection).
- Rotation logic is inline as a function in the package.

## Test plan
- **Encrypt, standard vector.**
  - Stimulus: key 0x133457799BBCDFF1 (hex, DES bit 1 = MSB, mapped to `key[1]`), `decrypt` = 0, `sk_ready` = 1.
  - Response: K1 = 0x1B02EFFC7072 in T+1; K16 = 0xCB3D8B0E17F5 with `last` in T+16; `done` in T+17.
- **Decrypt.**
  - Stimulus: same key, `decrypt` = 1.
  - Response: first subkey 0xCB3D8B0E17F5, last subkey 0x1B02EFFC7072; 16 subkeys total.
- **Backpressure.**
  - Stimulus: `sk_ready` toggling 1,0,0,1…
  - Response: `subkey` and `round` hold while stalled; sequence identical to the ungated run; `done` only after the 16th handshake.
- **Start while busy; back-to-back.**
  - Stimulus: `start` pulsed at round 5.
  - Response: ignored, stream unaffected.
  - Stimulus: `start` in the `done` cycle.
  - Response: new stream begins next cycle.
- **Reset mid-stream.**
  - Stimulus: `rst_n` low at round 7.
  - Response: all outputs 0 immediately, no `done`. A fresh `start` then gives K1 correct.
- **Parity (`DES_KS_PARITY_EN`).**
  - Stimulus: key 0x123457799BBCDFF1.
  - Response: `key_err` pulse in T+1, `busy` stays 0.
  - Stimulus: key 0x133457799BBCDFF1.
  - Response: accepted.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: widths, state enum, shift schedule
// and the C/D half-rotation helper.
package des_pkg;

    localparam int KEY_W  = 64;
    localparam int HALF_W = 28;
    localparam int SK_W   = 48;

    typedef enum logic {
        IDLE,
        ROUND
    } state_t;

    // Index 0 holds the shift for round 1.
    localparam logic [1:0] SHIFT_SCHED [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // MSB of a half is DES bit 1, so a DES left rotate moves bits
    // toward the MSB.
    function automatic logic [HALF_W-1:0] rot(
        input logic [HALF_W-1:0] x,
        input logic [1:0]        n,
        input logic              right
    );
        logic [2*HALF_W-1:0] t;
        if (right) begin
            t   = {x, x} >> n;
            rot = t[HALF_W-1:0];
        end else begin
            t   = {x, x} << n;
            rot = t[2*HALF_W-1:HALF_W];
        end
    endfunction

endpackage

// File: rtl/des_key_sched_if.sv
// Subkey stream handshake: sk_valid/sk_ready plus subkey, round, last.
// master = key scheduler, slave = round engine.
interface des_key_sched_if;

    logic                   sk_valid;
    logic                   sk_ready;
    logic [des_pkg::SK_W:0] subkey;
    logic [3:0]             round;
    logic                   last;

    modport master (
        output sk_valid, subkey, round, last,
        input  sk_ready
    );

    modport slave (
        input  sk_valid, subkey, round, last,
        output sk_ready
    );

endinterface

// File: rtl/des_pc1.sv
// DES PC1 permutation: key[n] is DES bit n; cd[i] is PC1 output bit i.
// Ports: key (64 DES bits), cd (56 bits, C = cd[1:28], D = cd[29:56]).
module des_pc1 (
    input  logic [64:1] key,
    output logic [1:56] cd
);

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    for (genvar i = 0; i < 56; i++) begin : g_bit
        assign cd[i+1] = key[PC1[i]];
    end

endmodule

// File: rtl/des_pc2.sv
// DES PC2 selection, 56 -> 48 bits.
// Ports: cd (C/D, cd[1] = C bit 1), sk (sk[n] = subkey bit n).
module des_pc2 (
    input  logic [1:56] cd,
    output logic [48:1] sk
);

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    for (genvar i = 0; i < 48; i++) begin : g_bit
        assign sk[i+1] = cd[PC2[i]];
    end

endmodule

// File: rtl/des_key_sched.sv
// DES key-schedule sequencer: loads key via PC1, streams 16 PC2 subkeys
// in encrypt or decrypt order over the sk handshake.
// Ports: clk, rst_n (async low), start, decrypt, key[64:1], busy, done,
// key_err (only with DES_KS_PARITY_EN), sk (master modport).
module des_key_sched
    import des_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             decrypt,
    input  logic [KEY_W:0]   key,
    output logic             busy,
    output logic             done,
`ifdef DES_KS_PARITY_EN
    output logic             key_err,
`endif
    des_key_sched_if.master  sk
);

    state_t              state_q, state_d;
    logic [3:0]          rnd_q, rnd_d;
    logic                dec_q, dec_d;
    logic [HALF_W-1:0]   c_q, c_d, d_q, d_d;
    logic                done_q, done_d;
    logic [1:56]         pc1_cd;
    logic [SK_W:1]       pc2_sk;
    logic [1:0]          sh;
    logic [1:0]          sh0;
    logic                hs;
    logic                key_ok;
    logic                unused_key0;

    assign unused_key0 = key[0];

    des_pc1 u_pc1 (
        .key (key[KEY_W:1]),
        .cd  (pc1_cd)
    );

    des_pc2 u_pc2 (
        .cd ({c_q, d_q}),
        .sk (pc2_sk)
    );

`ifdef DES_KS_PARITY_EN
    logic err_q, err_d;

    // Every byte must carry odd parity.
    assign key_ok = (^key[8:1])   & (^key[16:9])
                  & (^key[24:17]) & (^key[32:25])
                  & (^key[40:33]) & (^key[48:41])
                  & (^key[56:49]) & (^key[64:57]);
    assign key_err = err_q;
`else
    assign key_ok = 1'b1;
`endif

    assign hs  = sk.sk_valid & sk.sk_ready;
    assign sh0 = decrypt ? 2'd0 : SHIFT_SCHED[0];
    // Decrypt walks the schedule backwards with right rotates.
    assign sh  = dec_q ? SHIFT_SCHED[4'd15 - rnd_q]
                       : SHIFT_SCHED[rnd_q + 4'd1];

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        dec_d   = dec_q;
        c_d     = c_q;
        d_d     = d_q;
        done_d  = 1'b0;
`ifdef DES_KS_PARITY_EN
        err_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (start && key_ok) begin
                    state_d = ROUND;
                    rnd_d   = 4'd0;
                    dec_d   = decrypt;
                    c_d     = rot(pc1_cd[1:28], sh0, 1'b0);
                    d_d     = rot(pc1_cd[29:56], sh0, 1'b0);
                end
`ifdef DES_KS_PARITY_EN
                err_d = start & ~key_ok;
`endif
            end
            ROUND: begin
                if (hs) begin
                    if (rnd_q == 4'd15) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rnd_d = rnd_q + 4'd1;
                        c_d   = rot(c_q, sh, dec_q);
                        d_d   = rot(d_q, sh, dec_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            dec_q   <= 1'b0;
            c_q     <= '0;
            d_q     <= '0;
            done_q  <= 1'b0;
`ifdef DES_KS_PARITY_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            dec_q   <= dec_d;
            c_q     <= c_d;
            d_q     <= d_d;
            done_q  <= done_d;
`ifdef DES_KS_PARITY_EN
            err_q   <= err_d;
`endif
        end
    end

    assign busy        = (state_q == ROUND);
    assign done        = done_q;
    assign sk.sk_valid = busy;
    assign sk.round    = rnd_q;
    assign sk.last     = busy & (rnd_q == 4'd15);
    assign sk.subkey   = busy ? {pc2_sk, 1'b0} : '0;

endmodule
